// File: rtl/pattern_pwm_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pwm_pkg
// Shared definitions for the multi-channel pattern PWM generator: the
// per-channel state encoding and the default parameter values used by the
// top level and the channel engine.
// -----------------------------------------------------------------------------
package pattern_pwm_pkg;

  // Channel state: IDLE holds the idle level, RUN serialises the pattern
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_PAT_W  = 8;
  localparam int DEF_DUTY_W = 8;
  localparam int DEF_RPT_W  = 4;

endpackage : pattern_pwm_pkg

// File: rtl/pattern_pwm_ch.sv
// -----------------------------------------------------------------------------
// pattern_pwm_ch
// Single-channel pattern PWM engine. On an accepted start it latches the
// pattern and its playback settings, then shifts the pattern out one bit at
// a time, holding each bit for D+1 cycles and playing the whole pattern R+1
// times. The output is registered so that it changes exactly on clock edges.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start_i      start request (level-sampled, ignored while running)
//   abort_i      synchronous abort, highest priority
//   pat_i        pattern to play
//   duty_num_i   per-bit hold count D (bit lasts D+1 cycles)
//   rpt_num_i    repeat count R (pattern plays R+1 times)
//   msb_first_i  1: send bit PAT_W-1 first, 0: send bit 0 first
//   idle_lvl_i   output level while idle
//   pwm_out_o    registered serial output
//   busy_o       channel is playing a pattern
//   done_o       one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module pattern_pwm_ch
  import pattern_pwm_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RPT_W  = DEF_RPT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PAT_W-1:0]  pat_i,
  input  logic [DUTY_W-1:0] duty_num_i,
  input  logic [RPT_W-1:0]  rpt_num_i,
  input  logic              msb_first_i,
  input  logic              idle_lvl_i,
  output logic              pwm_out_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  pwm_state_e        state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic              msb_q, msb_d;
  logic              idle_q, idle_d;
  logic [DUTY_W-1:0] duty_cnt_q, duty_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              pwm_q, pwm_d;
  logic              done_q, done_d;

  // Picks the pattern bit for a given position in the shift sequence,
  // mirroring the position when the pattern is sent MSB first.
  function automatic logic sel_bit(input logic [PAT_W-1:0] p,
                                   input logic [BIT_W-1:0] cnt,
                                   input logic             msb);
    logic [BIT_W-1:0] idx;
    idx = msb ? (LAST_BIT - cnt) : cnt;
    return p[idx];
  endfunction

  // State, latched settings, counters and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      duty_q     <= '0;
      rpt_q      <= '0;
      msb_q      <= 1'b0;
      idle_q     <= 1'b0;
      duty_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rpt_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      duty_q     <= duty_d;
      rpt_q      <= rpt_d;
      msb_q      <= msb_d;
      idle_q     <= idle_d;
      duty_cnt_q <= duty_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. The output bit is computed from the next counter
  // values so the registered output lines up with the counters it reflects.
  // The final bit period returns straight to IDLE, which makes the done
  // cycle an IDLE cycle in which a new start can already be accepted.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    duty_d     = duty_q;
    rpt_d      = rpt_q;
    msb_d      = msb_q;
    idle_d     = idle_q;
    duty_cnt_d = duty_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    pwm_d      = pwm_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pwm_d = idle_q;
        if (start_i && !abort_i) begin
          state_d    = ST_RUN;
          pat_d      = pat_i;
          duty_d     = duty_num_i;
          rpt_d      = rpt_num_i;
          msb_d      = msb_first_i;
          idle_d     = idle_lvl_i;
          duty_cnt_d = '0;
          bit_cnt_d  = '0;
          rpt_cnt_d  = '0;
          pwm_d      = sel_bit(pat_i, '0, msb_first_i);
        end
      end

      ST_RUN: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          duty_cnt_d = '0;
          bit_cnt_d  = '0;
          rpt_cnt_d  = '0;
          pwm_d      = idle_q;
        end else if (duty_cnt_q == duty_q) begin
          duty_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (rpt_cnt_q == rpt_q) begin
              state_d   = ST_IDLE;
              rpt_cnt_d = '0;
              done_d    = 1'b1;
              pwm_d     = idle_q;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
              pwm_d     = sel_bit(pat_q, '0, msb_q);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            pwm_d     = sel_bit(pat_q, bit_cnt_q + 1'b1, msb_q);
          end
        end else begin
          duty_cnt_d = duty_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pwm_out_o = pwm_q;
  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = done_q;

endmodule : pattern_pwm_ch

// File: rtl/pattern_pwm_mc.sv
// -----------------------------------------------------------------------------
// pattern_pwm_mc
// Multi-channel pattern PWM generator. Instantiates NUM_CH independent
// channel engines and slices the packed configuration buses among them.
// Channel c uses pat[c*PAT_W +: PAT_W], duty_num[c*DUTY_W +: DUTY_W] and
// rpt_num[c*RPT_W +: RPT_W]; all single-bit buses are indexed by c.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        per-channel start request
//   abort        per-channel synchronous abort
//   pat          packed patterns
//   duty_num     packed per-bit hold counts
//   rpt_num      packed repeat counts
//   msb_first    per-channel shift order
//   idle_lvl     per-channel idle output level
//   pwm_out      per-channel serial output
//   busy         per-channel playing flag
//   done         per-channel completion pulse
// -----------------------------------------------------------------------------
module pattern_pwm_mc
  import pattern_pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RPT_W  = DEF_RPT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        abort,
  input  logic [NUM_CH*PAT_W-1:0]  pat,
  input  logic [NUM_CH*DUTY_W-1:0] duty_num,
  input  logic [NUM_CH*RPT_W-1:0]  rpt_num,
  input  logic [NUM_CH-1:0]        msb_first,
  input  logic [NUM_CH-1:0]        idle_lvl,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pattern_pwm_ch #(
      .PAT_W (PAT_W),
      .DUTY_W(DUTY_W),
      .RPT_W (RPT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start[c]),
      .abort_i    (abort[c]),
      .pat_i      (pat[c*PAT_W +: PAT_W]),
      .duty_num_i (duty_num[c*DUTY_W +: DUTY_W]),
      .rpt_num_i  (rpt_num[c*RPT_W +: RPT_W]),
      .msb_first_i(msb_first[c]),
      .idle_lvl_i (idle_lvl[c]),
      .pwm_out_o  (pwm_out[c]),
      .busy_o     (busy[c]),
      .done_o     (done[c])
    );
  end

endmodule : pattern_pwm_mc

// File: tb/tb_pattern_pwm_mc.sv
// -----------------------------------------------------------------------------
// tb_pattern_pwm_mc
// Directed testbench for pattern_pwm_mc with four 8-bit channels. Expected
// waveforms are written out by hand from the pattern constants and timing
// rules; every comparison goes through checkOutput.
// -----------------------------------------------------------------------------
module tb_pattern_pwm_mc;

  localparam int NUM_CH = 4;
  localparam int PAT_W  = 8;
  localparam int DUTY_W = 8;
  localparam int RPT_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        abort;
  logic [NUM_CH*PAT_W-1:0]  pat;
  logic [NUM_CH*DUTY_W-1:0] duty_num;
  logic [NUM_CH*RPT_W-1:0]  rpt_num;
  logic [NUM_CH-1:0]        msb_first;
  logic [NUM_CH-1:0]        idle_lvl;
  logic [NUM_CH-1:0]        pwm_out;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;

  int checkCount = 0;
  int errCount   = 0;

  pattern_pwm_mc #(
    .NUM_CH(NUM_CH),
    .PAT_W (PAT_W),
    .DUTY_W(DUTY_W),
    .RPT_W (RPT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pat      (pat),
    .duty_num (duty_num),
    .rpt_num  (rpt_num),
    .msb_first(msb_first),
    .idle_lvl (idle_lvl),
    .pwm_out  (pwm_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Load one channel's configuration onto the packed input buses
  task automatic applyStimulus(input int c, input logic [7:0] p,
                               input logic [7:0] d, input logic [3:0] r,
                               input logic msb, input logic idle);
    pat[c*PAT_W +: PAT_W]        = p;
    duty_num[c*DUTY_W +: DUTY_W] = d;
    rpt_num[c*RPT_W +: RPT_W]    = r;
    msb_first[c]                 = msb;
    idle_lvl[c]                  = idle;
  endtask

  // Channel 0: A5, D=0, R=0, LSB first, idle 0 -> 1,0,1,0,0,1,0,1 then done
  task automatic runCh0(input string pfx);
    logic [7:0] expv;
    expv = 8'hA5;
    applyStimulus(0, 8'hA5, 8'd0, 4'd0, 1'b0, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s bit%0d", pfx, k), 64'(pwm_out[0]), 64'(expv[k]));
      checkOutput($sformatf("%s busy%0d", pfx, k), 64'(busy[0]), 64'd1);
      tick();
    end
    checkOutput({pfx, " done pulse"}, 64'(done[0]), 64'd1);
    checkOutput({pfx, " busy end"}, 64'(busy[0]), 64'd0);
    checkOutput({pfx, " idle out"}, 64'(pwm_out[0]), 64'd0);
    tick();
    checkOutput({pfx, " done single"}, 64'(done[0]), 64'd0);
  endtask

  initial begin
    logic [7:0] expv;
    logic [7:0] pats [NUM_CH];
    logic [3:0] expVec;
    int         doneSeen;
    int         k;

    rst_n     = 1'b0;
    start     = '0;
    abort     = '0;
    pat       = '0;
    duty_num  = '0;
    rpt_num   = '0;
    msb_first = '0;
    idle_lvl  = '0;

    // Reset state
    tick();
    tick();
    checkOutput("reset pwm", 64'(pwm_out), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset done", 64'(done), 64'h0);
    rst_n = 1'b1;
    tick();

    // Basic LSB-first single pass
    runCh0("ch0");

    // Channel 1: 81, D=2, R=1, MSB first, idle 1; inputs changed mid-run
    checkOutput("ch1 pre idle", 64'(pwm_out[1]), 64'd0);
    expv = 8'h81;
    applyStimulus(1, 8'h81, 8'd2, 4'd1, 1'b1, 1'b1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    applyStimulus(1, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      k = (i / 3) % 8;
      checkOutput($sformatf("ch1 cyc%0d", i), 64'(pwm_out[1]), 64'(expv[7-k]));
      checkOutput($sformatf("ch1 busy%0d", i), 64'(busy[1]), 64'd1);
      tick();
    end
    checkOutput("ch1 done pulse", 64'(done[1]), 64'd1);
    checkOutput("ch1 busy end", 64'(busy[1]), 64'd0);
    checkOutput("ch1 idle out", 64'(pwm_out[1]), 64'd1);
    tick();
    checkOutput("ch1 done single", 64'(done[1]), 64'd0);
    checkOutput("ch1 idle hold", 64'(pwm_out[1]), 64'd1);

    // Channel 2: F0, D=3, idle 1, abort in cycle 5 (bit 1 = 0)
    applyStimulus(2, 8'hF0, 8'd3, 4'd0, 1'b0, 1'b1);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("ch2 pre-abort bit", 64'(pwm_out[2]), 64'd0);
    checkOutput("ch2 pre-abort busy", 64'(busy[2]), 64'd1);
    abort[2] = 1'b1;
    tick();
    abort[2] = 1'b0;
    checkOutput("ch2 abort busy", 64'(busy[2]), 64'd0);
    checkOutput("ch2 abort out", 64'(pwm_out[2]), 64'd1);
    checkOutput("ch2 abort done", 64'(done[2]), 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done[2]) doneSeen++;
      tick();
    end
    checkOutput("ch2 no done", 64'(doneSeen), 64'd0);
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    abort[2] = 1'b0;
    checkOutput("ch2 abort blocks start", 64'(busy[2]), 64'd0);
    checkOutput("ch2 blocked out", 64'(pwm_out[2]), 64'd1);

    // Channel 3: 3C, D=0, R=0, start held high -> restart on done cycle
    expv = 8'h3C;
    applyStimulus(3, 8'h3C, 8'd0, 4'd0, 1'b0, 1'b0);
    start[3] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ch3 bit%0d", i), 64'(pwm_out[3]), 64'(expv[i]));
      if (i == 3) pat[31:24] = 8'hFF;
      if (i == 5) pat[31:24] = 8'h3C;
      tick();
    end
    checkOutput("ch3 gap done", 64'(done[3]), 64'd1);
    checkOutput("ch3 gap busy", 64'(busy[3]), 64'd0);
    checkOutput("ch3 gap out", 64'(pwm_out[3]), 64'd0);
    tick();
    checkOutput("ch3 restart busy", 64'(busy[3]), 64'd1);
    checkOutput("ch3 restart bit0", 64'(pwm_out[3]), 64'(expv[0]));
    tick();
    checkOutput("ch3 restart bit1", 64'(pwm_out[3]), 64'(expv[1]));
    start[3] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("ch3 bit7 busy", 64'(busy[3]), 64'd1);
    checkOutput("ch3 bit7 out", 64'(pwm_out[3]), 64'(expv[7]));
    tick();
    checkOutput("ch3 second done", 64'(done[3]), 64'd1);
    tick();
    checkOutput("ch3 stays idle", 64'(busy[3]), 64'd0);

    // All channels together: D=1, R=0, distinct patterns, aligned edges
    pats[0] = 8'h12;
    pats[1] = 8'hC3;
    pats[2] = 8'h5A;
    pats[3] = 8'hE7;
    for (int c = 0; c < NUM_CH; c++) applyStimulus(c, pats[c], 8'd1, 4'd0, 1'b0, 1'b0);
    start = 4'hF;
    tick();
    start = 4'h0;
    for (int i = 0; i < 16; i++) begin
      k = i / 2;
      for (int c = 0; c < NUM_CH; c++) expVec[c] = pats[c][k];
      checkOutput($sformatf("all cyc%0d", i), 64'(pwm_out), 64'(expVec));
      checkOutput($sformatf("all busy%0d", i), 64'(busy), 64'hF);
      tick();
    end
    checkOutput("all done aligned", 64'(done), 64'hF);
    checkOutput("all busy end", 64'(busy), 64'h0);
    checkOutput("all idle out", 64'(pwm_out), 64'h0);
    tick();

    // Reset mid-pattern: ch0 A5 (bit2=1 in cycle 3), ch1 00 idle 1, ch2 idle 1
    applyStimulus(0, 8'hA5, 8'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1, 8'h00, 8'd0, 4'd0, 1'b0, 1'b1);
    applyStimulus(2, 8'hFF, 8'd0, 4'd0, 1'b0, 1'b1);
    start = 4'b0011;
    tick();
    start = 4'b0000;
    tick();
    tick();
    checkOutput("pre-reset pwm", 64'(pwm_out), 64'h1);
    checkOutput("pre-reset busy", 64'(busy), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset pwm", 64'(pwm_out), 64'h0);
    checkOutput("async reset busy", 64'(busy), 64'h0);
    checkOutput("async reset done", 64'(done), 64'h0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 8'h00, 8'd0, 4'd0, 1'b0, 1'b0);
    runCh0("ch0 rerun");
    checkOutput("rerun others idle", 64'(busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule : tb_pattern_pwm_mc
